// File: rtl/seven_segment_scanner.sv
// Multiplexed hex seven-segment scanner with decimal points, PWM dimming,
// leading-zero blanking and a frame-synchronous load handshake.
module seven_segment_scanner #(
    parameter int NUM_DIGITS = 8,
    parameter int TICK_DIV   = 100000,
    parameter int DIM_BITS   = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] data,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic                    load,
    input  logic [DIM_BITS-1:0]     brightness,
    input  logic                    blank_zeros,
    output logic [7:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done,
    output logic                    pending
);

    localparam int IW = $clog2(NUM_DIGITS);
    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] ONE = NUM_DIGITS'(1);

    logic [PW-1:0]           presc_q, presc_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [DIM_BITS-1:0]     pwm_q, pwm_d;
    logic [4*NUM_DIGITS-1:0] stg_data_q, stg_data_d;
    logic [NUM_DIGITS-1:0]   stg_dp_q, stg_dp_d;
    logic [4*NUM_DIGITS-1:0] disp_data_q, disp_data_d;
    logic [NUM_DIGITS-1:0]   disp_dp_q, disp_dp_d;
    logic                    pend_q, pend_d;
    logic [7:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;

    logic                  tick;
    logic                  boundary;
    logic                  lit;
    logic [3:0]            nib;
    logic [NUM_DIGITS-1:0] blank;
    logic                  allz;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] r;
        case (n)
            4'h0: r = 7'h40;
            4'h1: r = 7'h79;
            4'h2: r = 7'h24;
            4'h3: r = 7'h30;
            4'h4: r = 7'h19;
            4'h5: r = 7'h12;
            4'h6: r = 7'h02;
            4'h7: r = 7'h78;
            4'h8: r = 7'h00;
            4'h9: r = 7'h10;
            4'hA: r = 7'h08;
            4'hB: r = 7'h03;
            4'hC: r = 7'h46;
            4'hD: r = 7'h21;
            4'hE: r = 7'h06;
            default: r = 7'h0E;
        endcase
        return r;
    endfunction

    assign tick     = (presc_q == TICK_LAST);
    assign boundary = tick && (idx_q == IDX_LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            presc_q     <= '0;
            idx_q       <= '0;
            pwm_q       <= '0;
            stg_data_q  <= '0;
            stg_dp_q    <= '0;
            disp_data_q <= '0;
            disp_dp_q   <= '0;
            pend_q      <= 1'b0;
            seg_q       <= 8'hFF;
            an_q        <= '1;
        end else begin
            presc_q     <= presc_d;
            idx_q       <= idx_d;
            pwm_q       <= pwm_d;
            stg_data_q  <= stg_data_d;
            stg_dp_q    <= stg_dp_d;
            disp_data_q <= disp_data_d;
            disp_dp_q   <= disp_dp_d;
            pend_q      <= pend_d;
            seg_q       <= seg_d;
            an_q        <= an_d;
        end
    end

    always_comb begin
        presc_d     = tick ? '0 : presc_q + 1'b1;
        pwm_d       = tick ? '0 : pwm_q + 1'b1;
        idx_d       = idx_q;
        stg_data_d  = stg_data_q;
        stg_dp_d    = stg_dp_q;
        disp_data_d = disp_data_q;
        disp_dp_d   = disp_dp_q;
        pend_d      = pend_q;
        if (tick) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
        // A load racing the boundary wins; its value waits for the next frame.
        if (load) begin
            stg_data_d = data;
            stg_dp_d   = dp;
            pend_d     = 1'b1;
        end else if (boundary && pend_q) begin
            disp_data_d = stg_data_q;
            disp_dp_d   = stg_dp_q;
            pend_d      = 1'b0;
        end
    end

    always_comb begin
        allz  = 1'b1;
        blank = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            allz     = allz && (disp_data_q[4*i +: 4] == 4'h0);
            blank[i] = blank_zeros && allz && (i != 0);
        end
    end

    always_comb begin
        lit   = (&brightness) || (pwm_q < brightness);
        nib   = disp_data_q[4*int'(idx_q) +: 4];
        seg_d = 8'hFF;
        an_d  = '1;
        if (lit) begin
            an_d  = ~(ONE << idx_q);
            seg_d = {~disp_dp_q[idx_q], blank[idx_q] ? 7'h7F : hex7(nib)};
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign frame_done = boundary;
    assign pending    = pend_q;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Bench for seven_segment_scanner: a cycle-count reference model
// checks every cycle, plus directed scenarios for load, dimming and reset.
module tb_seven_segment_scanner;

    localparam int ND = 4;
    localparam int TD = 8;
    localparam int DB = 2;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] data;
    logic [3:0]  dp;
    logic        load;
    logic [1:0]  brightness;
    logic        blank_zeros;
    logic [7:0]  seg;
    logic [3:0]  an;
    logic        frame_done;
    logic        pending;

    int n_chk  = 0;
    int n_fail = 0;

    int          cyc;
    logic [15:0] m_disp, m_stg;
    logic [3:0]  m_dpd, m_dps;
    logic        m_pend;
    logic [7:0]  e_seg;
    logic [3:0]  e_an;
    logic [7:0]  cap [ND];
    int          lit_cnt;
    time         t0;

    logic [7:0] lut [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    seven_segment_scanner #(
        .NUM_DIGITS(ND),
        .TICK_DIV  (TD),
        .DIM_BITS  (DB)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .data       (data),
        .dp         (dp),
        .load       (load),
        .brightness (brightness),
        .blank_zeros(blank_zeros),
        .seg        (seg),
        .an         (an),
        .frame_done (frame_done),
        .pending    (pending)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        assert (got === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        cyc    = 0;
        m_disp = '0;
        m_stg  = '0;
        m_dpd  = '0;
        m_dps  = '0;
        m_pend = 1'b0;
    endtask

    // One clock: predict outputs from the pre-edge position, then compare.
    task automatic cycle();
        int   ps, idx, pwm;
        logic lit, blk;
        logic [3:0] nib;
        @(posedge clock);
        ps  = cyc % TD;
        idx = (cyc / TD) % ND;
        pwm = ps % (1 << DB);
        lit = (&brightness) || (pwm < int'(brightness));
        nib = m_disp[4*idx +: 4];
        blk = blank_zeros && (idx > 0) && ((m_disp >> (4*idx)) == 16'h0);
        if (lit) begin
            e_an  = ~(4'b0001 << idx);
            e_seg = {~m_dpd[idx], blk ? 7'h7F : lut[nib][6:0]};
        end else begin
            e_an  = 4'hF;
            e_seg = 8'hFF;
        end
        if (load) begin
            m_stg  = data;
            m_dps  = dp;
            m_pend = 1'b1;
        end else if (ps == TD-1 && idx == ND-1 && m_pend) begin
            m_disp = m_stg;
            m_dpd  = m_dps;
            m_pend = 1'b0;
        end
        cyc++;
        #1;
        chk("an", an, e_an);
        chk("seg", seg, e_seg);
        chk("frame_done", frame_done, (cyc % (TD*ND)) == TD*ND - 1);
        chk("pending", pending, m_pend);
        chk("an_onehot", $countones(~an) <= 1, 1);
    endtask

    task automatic wait_fd();
        int k;
        k = 0;
        while (frame_done !== 1'b1 && k < 40) begin
            cycle();
            k++;
        end
        chk("fd_timeout", frame_done, 1'b1);
    endtask

    task automatic run_frame();
        for (int d = 0; d < ND; d++) cap[d] = 8'h00;
        for (int k = 0; k < TD*ND; k++) begin
            cycle();
            for (int d = 0; d < ND; d++)
                if (an === ~(4'b0001 << d)) cap[d] = seg;
        end
    endtask

    task automatic show(input logic [15:0] v, input logic [3:0] p);
        data = v;
        dp   = p;
        load = 1'b1;
        cycle();
        load = 1'b0;
        chk("pend_set", pending, 1'b1);
        wait_fd();
        chk("pend_hold", pending, 1'b1);
        cycle();
        chk("pend_clr", pending, 1'b0);
        run_frame();
    endtask

    initial begin
        reset       = 1'b1;
        data        = '0;
        dp          = '0;
        load        = 1'b0;
        brightness  = 2'd3;
        blank_zeros = 1'b0;
        model_reset();
        #2;
        chk("rst_an", an, 4'hF);
        chk("rst_seg", seg, 8'hFF);
        chk("rst_fd", frame_done, 1'b0);
        chk("rst_pend", pending, 1'b0);
        #20;
        reset = 1'b0;

        cycle();
        chk("first_an", an, 4'b1110);
        chk("first_seg", seg, 8'hC0);
        wait_fd();
        t0 = $time;
        cycle();
        wait_fd();
        chk("frame_period", 32'($time - t0), 32'(10*TD*ND));

        show(16'h12AF, 4'b0001);
        chk("d0_12AF", cap[0], 8'h0E);
        chk("d1_12AF", cap[1], 8'h88);
        chk("d2_12AF", cap[2], 8'hA4);
        chk("d3_12AF", cap[3], 8'hF9);

        brightness = 2'd1;
        wait_fd();
        cycle();
        lit_cnt = 0;
        for (int k = 0; k < TD; k++) begin
            cycle();
            if (an !== 4'hF) lit_cnt++;
        end
        chk("pwm_b1", lit_cnt, 2);
        brightness = 2'd0;
        cycle();
        lit_cnt = 0;
        for (int k = 0; k < TD*ND; k++) begin
            cycle();
            if (an !== 4'hF) lit_cnt++;
        end
        chk("pwm_b0", lit_cnt, 0);

        brightness  = 2'd3;
        blank_zeros = 1'b1;
        show(16'h0050, 4'b0000);
        chk("d3_0050", cap[3], 8'hFF);
        chk("d2_0050", cap[2], 8'hFF);
        chk("d1_0050", cap[1], 8'h92);
        chk("d0_0050", cap[0], 8'hC0);
        show(16'h0000, 4'b0000);
        chk("d3_0000", cap[3], 8'hFF);
        chk("d2_0000", cap[2], 8'hFF);
        chk("d1_0000", cap[1], 8'hFF);
        chk("d0_0000", cap[0], 8'hC0);

        blank_zeros = 1'b0;
        wait_fd();
        data = 16'h1111;
        load = 1'b1;
        cycle();
        load = 1'b0;
        chk("race_pend", pending, 1'b1);
        wait_fd();
        chk("race_pend2", pending, 1'b1);
        cycle();
        chk("race_clr", pending, 1'b0);
        run_frame();
        for (int d = 0; d < ND; d++) chk("race_val", cap[d], 8'hF9);

        for (int k = 0; k < 800; k++) begin
            load = ($urandom_range(0, 5) == 0);
            data = 16'($urandom);
            dp   = 4'($urandom);
            if ($urandom_range(0, 31) == 0) brightness = 2'($urandom);
            if ($urandom_range(0, 63) == 0) blank_zeros = 1'($urandom);
            cycle();
        end

        brightness = 2'd3;
        data       = 16'h5555;
        load       = 1'b1;
        begin
            int k;
            k = 0;
            cycle();
            while (an !== 4'b1011 && k < 40) begin
                cycle();
                k++;
            end
        end
        chk("seek_d2", an, 4'b1011);
        chk("pre_rst_pend", pending, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_an", an, 4'hF);
        chk("async_seg", seg, 8'hFF);
        chk("async_pend", pending, 1'b0);
        chk("async_fd", frame_done, 1'b0);
        load = 1'b0;
        #20;
        reset = 1'b0;
        model_reset();
        cycle();
        chk("restart_an", an, 4'b1110);
        chk("restart_seg", seg, 8'hC0);
        for (int k = 0; k < 40; k++) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/seven_segment_scanner.md
Name: seven_segment_scanner

Overview:
Parametrised multiplexed seven-segment driver, the successor to the fixed 8-digit display block. It scans NUM_DIGITS common-anode digits and decodes the full hex range 0-F. It adds per-digit decimal points, PWM brightness, optional leading-zero blanking, and a frame-synchronous load handshake so a displayed value never tears mid-scan. It sits between the miner status/nonce registers and the board's active-low AN/CA pins.

Parameters:
NUM_DIGITS, 8, number of digits scanned (>=2)
TICK_DIV, 100000, clock cycles per digit slot (>=2); 100 MHz gives 1 kHz per digit
DIM_BITS, 4, brightness resolution in bits (>=1)

Ports:
clock  in  1  system clock; sole clock domain
reset  in  1  asynchronous, active-high reset
data  in  4*NUM_DIGITS  hex nibbles; data[3:0] is digit 0 (rightmost)
dp  in  NUM_DIGITS  decimal point enables, active-high; dp[i] belongs to digit i
load  in  1  single-cycle strobe; captures data/dp into the staging register
brightness  in  DIM_BITS  0 = dark, all-ones = full on
blank_zeros  in  1  1 = blank leading zero digits
seg  out  8  active-low {dp,g,f,e,d,c,b,a}
an  out  NUM_DIGITS  active-low digit enables; at most one bit low
frame_done  out  1  one-cycle pulse at each frame boundary
pending  out  1  staged value not yet displayed

Behaviour:
- Reset (async, takes effect immediately, including mid-frame): prescaler=0, index=0, pwm_cnt=0, staging and display registers=0, pending=0, an=all 1s, seg=8'hFF, frame_done=0.
- Prescaler: counts 0..TICK_DIV-1 and wraps to 0. A tick occurs in the cycle where count==TICK_DIV-1.
- Digit index: advances on each tick and wraps from NUM_DIGITS-1 to 0. The tick that wraps the index is the frame boundary, and frame_done=1 for exactly that cycle.
- Load handshake:
  - When load=1, data/dp are written to the staging register and pending is set to 1. If several loads arrive before a boundary, the last one wins.
  - At a frame boundary with pending=1 and no load in the same cycle, staging is copied to the display register and pending is cleared.
  - If load and a frame boundary coincide, the staging register takes the new value, the old staged value is not applied, and pending stays 1. The new value applies at the next boundary.
- PWM: pwm_cnt is DIM_BITS wide, increments every clock, and resets to 0 on each tick.
  - Digit enabled when brightness==all-ones, or when pwm_cnt < brightness.
  - brightness==0 keeps an all 1s.
- Leading-zero blanking: with blank_zeros=1, digit i (i>0) is blanked when display nibbles i..NUM_DIGITS-1 are all 0. Digit 0 is never blanked.
  - A blanked digit drives seg[6:0]=7'h7F and seg[7]=~dp[i]. Its anode still scans under PWM.
- Decode: seg[6:0] comes from the current display nibble (two-digit hex codes are 8-bit values; seg[6:0] is their low 7 bits).
  - 0:C0 1:F9 2:A4 3:B0 4:99 5:92 6:82 7:F8 8:80 9:90 A:88 b:83 C:C6 d:A1 E:86 F:8E.
  - seg[7]=~dp[index].
- Outputs: seg and an are registered and reflect index/pwm_cnt/display state with exactly 1 cycle of latency. When a digit is disabled by PWM, an=all 1s and seg=8'hFF.
- Index width is clog2(NUM_DIGITS). Prescaler width is clog2(TICK_DIV). No overflow beyond the wrap points.

Test Plan:
All scenarios use NUM_DIGITS=4, TICK_DIV=8, DIM_BITS=2.
- Reset then load data=16'h12AF, dp=4'b0001, brightness=3 -> pending=1 until the first frame_done; then per slot seg: digit0=8'h0E, digit1=8'h88, digit2=8'hA4, digit3=8'hF9, with an=1110,1101,1011,0111 in sequence.
- Free run after reset -> tick every 8 cycles, frame_done every 32 cycles and high for 1 cycle, never two an bits low at once.
- brightness=1 -> in each 8-cycle slot the digit is lit for cycles where pwm_cnt==0, i.e. 2 of 8 cycles. brightness=0 -> an stays 4'hF.
- blank_zeros=1, data=16'h0050 -> digits 3 and 2 show seg=8'hFF, digit 1 shows 8'h92, digit 0 shows 8'hC0. data=16'h0000 -> only digit 0 shows 8'hC0.
- load asserted in the same cycle as frame_done with data=16'h1111 -> old display persists one more frame and pending stays 1; 16'h1111 appears after the next frame_done.
- reset asserted mid-slot while digit 2 is lit -> an=4'hF and seg=8'hFF in the same cycle without a clock edge, and pending=0. After release, scanning restarts at digit 0 showing 0.
